// File: rtl/event_pkg.sv
// event_pkg -- shared constants for the event queue and its producers.
//
// Contents:
//   EVQ_DEPTH_DEF   default FIFO depth
//   EVQ_EMPTY_CODE  value presented on the data port while the queue is empty
//   EVQ_OVF_MARK    marker code queued after an overflow (EVENT_QUEUE_OVF_MARK_EN builds)
//   evt_kind_e      event kind field, bits [7:6] of an event code
//   EVID_*          source identifiers, bits [5:0] of an event code
//   evq_make_code   packs kind + id into an 8-bit event code
package event_pkg;

    localparam int         EVQ_DEPTH_DEF  = 8;
    localparam logic [7:0] EVQ_EMPTY_CODE = 8'h00;
    localparam logic [7:0] EVQ_OVF_MARK   = 8'hFF;

    typedef enum logic [1:0] {
        EVK_NONE    = 2'b00,
        EVK_PRESS   = 2'b01,
        EVK_RELEASE = 2'b10
    } evt_kind_e;

    localparam logic [5:0] EVID_BUTTON_0 = 6'd32;
    localparam logic [5:0] EVID_BUTTON_1 = 6'd33;
    localparam logic [5:0] EVID_PEDAL_0  = 6'd36;
    localparam logic [5:0] EVID_PEDAL_1  = 6'd37;
    localparam logic [5:0] EVID_PEDAL_2  = 6'd38;

    function automatic logic [7:0] evq_make_code(evt_kind_e kind, logic [5:0] id);
        return {kind, id};
    endfunction

endpackage

// File: rtl/evq_strobe_sync.sv
// evq_strobe_sync -- brings an asynchronous MCU strobe into the clk domain
// and turns its rising edge into a single-cycle pulse.
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset (clears all synchronizer flops)
//   strb_i   asynchronous strobe, active high
//   pulse_o  one-cycle pulse, high in the cycle after the strobe reaches the
//            second synchronizer stage
module evq_strobe_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic strb_i,
    output logic pulse_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= strb_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign pulse_o = sync_q & ~prev_q;

endmodule

// File: rtl/event_queue.sv
// event_queue -- merges two event-strobe sources into one FIFO and presents
// the head entry to the host MCU with an IRQ line.
//
// Ports:
//   clk, rst_n        1 MHz system clock, asynchronous active-low reset
//   evFlagA/evCodeA   source A strobe + code (patient button / pedal)
//   evFlagB/evCodeB   source B strobe + code (keyboard)
//   rdStrb            asynchronous host read strobe; each rising edge pops one entry
//   clrOvf            one-cycle pulse clearing ovfFlag
//   dataOut           registered head entry, EVQ_EMPTY_CODE when empty
//   irq               high while the queue is non-empty
//   count             current occupancy, 0..DEPTH
//   ovfFlag           sticky: at least one event was dropped
//
// Build option: define EVENT_QUEUE_OVF_MARK_EN to queue an EVQ_OVF_MARK entry
// at the first free, flag-free cycle after an overflow.
module event_queue
    import event_pkg::*;
#(
    parameter int DEPTH = EVQ_DEPTH_DEF,
    parameter int CW    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   evFlagA,
    input  logic [CW-1:0]          evCodeA,
    input  logic                   evFlagB,
    input  logic [CW-1:0]          evCodeB,
    input  logic                   rdStrb,
    input  logic                   clrOvf,
    output logic [CW-1:0]          dataOut,
    output logic                   irq,
    output logic [$clog2(DEPTH):0] count,
    output logic                   ovfFlag
);

    localparam int PW = $clog2(DEPTH);
    localparam int NW = PW + 1;

    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [NW-1:0] count_q, count_d;
    logic [CW-1:0] mem_q [DEPTH];
    logic [CW-1:0] mem_d [DEPTH];
    logic [CW-1:0] data_q, data_d;
    logic          irq_q, irq_d;
    logic          ovf_q, ovf_d;

    logic          rd_pulse;
    logic          pop;
    logic [NW-1:0] free;
    logic          acc_a, acc_b, drop, mark_push;
    logic [NW-1:0] n_push;

    evq_strobe_sync u_rd_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .strb_i  (rdStrb),
        .pulse_o (rd_pulse)
    );

`ifdef EVENT_QUEUE_OVF_MARK_EN
    logic mark_q, mark_d;

    // Armed only by the first drop since the flag was last clear; a clear in
    // the same cycle as a drop counts as "clear".
    always_comb begin
        mark_d = mark_q;
        if (mark_push) begin
            mark_d = 1'b0;
        end else if (drop && (!ovf_q || clrOvf)) begin
            mark_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mark_q <= 1'b0;
        end else begin
            mark_q <= mark_d;
        end
    end
`endif

    always_comb begin
        pop  = rd_pulse && (count_q != '0);
        // A pop in the same cycle frees its slot for this cycle's pushes.
        free = NW'(DEPTH) - count_q + NW'(pop);

        acc_a = evFlagA && (free != '0);
        acc_b = evFlagB && (free > NW'(acc_a));
        drop  = (evFlagA && !acc_a) || (evFlagB && !acc_b);

`ifdef EVENT_QUEUE_OVF_MARK_EN
        mark_push = mark_q && !evFlagA && !evFlagB && (free != '0);
`else
        mark_push = 1'b0;
`endif

        mem_d = mem_q;
        wp_d  = wp_q;
        if (acc_a) begin
            mem_d[wp_d] = evCodeA;
            wp_d        = wp_d + PW'(1);
        end
        if (acc_b) begin
            mem_d[wp_d] = evCodeB;
            wp_d        = wp_d + PW'(1);
        end
        if (mark_push) begin
            mem_d[wp_d] = CW'(EVQ_OVF_MARK);
            wp_d        = wp_d + PW'(1);
        end

        n_push  = NW'(acc_a) + NW'(acc_b) + NW'(mark_push);
        rp_d    = rp_q + PW'(pop);
        count_d = count_q + n_push - NW'(pop);

        ovf_d = drop || (ovf_q && !clrOvf);

        // Outputs are taken from next state so a push into an empty queue is
        // visible right after the edge that accepts it.
        irq_d  = (count_d != '0);
        data_d = irq_d ? mem_d[rp_d] : CW'(EVQ_EMPTY_CODE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            data_q  <= CW'(EVQ_EMPTY_CODE);
            irq_q   <= 1'b0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            data_q  <= data_d;
            irq_q   <= irq_d;
            ovf_q   <= ovf_d;
            mem_q   <= mem_d;
        end
    end

    assign dataOut = data_q;
    assign irq     = irq_q;
    assign count   = count_q;
    assign ovfFlag = ovf_q;

endmodule

// File: tb/tb_event_queue.sv
`timescale 1ns/1ps
module tb_event_queue;
    import event_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW    = 8;

    logic                   clk     = 1'b0;
    logic                   rst_n   = 1'b1;
    logic                   evFlagA = 1'b0;
    logic                   evFlagB = 1'b0;
    logic                   rdStrb  = 1'b0;
    logic                   clrOvf  = 1'b0;
    logic [CW-1:0]          evCodeA = '0;
    logic [CW-1:0]          evCodeB = '0;
    logic [CW-1:0]          dataOut;
    logic                   irq;
    logic [$clog2(DEPTH):0] count;
    logic                   ovfFlag;

    event_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .evFlagA (evFlagA),
        .evCodeA (evCodeA),
        .evFlagB (evFlagB),
        .evCodeB (evCodeB),
        .rdStrb  (rdStrb),
        .clrOvf  (clrOvf),
        .dataOut (dataOut),
        .irq     (irq),
        .count   (count),
        .ovfFlag (ovfFlag)
    );

    always #500 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: queue contents, sticky overflow, pending marker, and
    // the edge numbers at which host reads take effect.
    logic [CW-1:0] mq[$];
    bit            m_ovf;
    bit            m_pend;
    int            cyc;
    int            pop_due[$];
    bit            rd_prev;

    task automatic check_outputs(input string where);
        chk($sformatf("%s count", where), 32'(count), 32'(mq.size()));
        chk($sformatf("%s irq", where), 32'(irq), 32'(mq.size() != 0));
        chk($sformatf("%s dataOut", where), 32'(dataOut),
            (mq.size() != 0) ? 32'(mq[0]) : 32'(EVQ_EMPTY_CODE));
        chk($sformatf("%s ovfFlag", where), 32'(ovfFlag), 32'(m_ovf));
    endtask

    // Called at a negedge: drives inputs for the next posedge, advances the
    // model over that edge, then checks at the following negedge.
    task automatic cycle(input bit fa, input logic [7:0] ca, input bit fb,
                         input logic [7:0] cb, input bit clr, input bit rd);
        bit pop;
        int free;
        bit acc_a, acc_b, drop;
        evFlagA = fa; evCodeA = ca; evFlagB = fb; evCodeB = cb;
        clrOvf = clr; rdStrb = rd;
        // A read strobe first sampled at edge cyc+1 takes effect at edge cyc+3.
        if (rd && !rd_prev) pop_due.push_back(cyc + 3);
        rd_prev = rd;
        @(posedge clk);
        cyc++;
        pop = 0;
        if (pop_due.size() > 0 && pop_due[0] == cyc) begin
            void'(pop_due.pop_front());
            pop = (mq.size() > 0);
        end
        free = DEPTH - mq.size() + (pop ? 1 : 0);
        if (pop) void'(mq.pop_front());
        acc_a = fa && (free >= 1);
        acc_b = fb && (free >= (acc_a ? 2 : 1));
        if (acc_a) mq.push_back(ca);
        if (acc_b) mq.push_back(cb);
        drop = (fa && !acc_a) || (fb && !acc_b);
`ifdef EVENT_QUEUE_OVF_MARK_EN
        if (m_pend && !fa && !fb && free > 0) begin
            mq.push_back(EVQ_OVF_MARK);
            m_pend = 0;
        end
        if (drop && (!m_ovf || clr)) m_pend = 1;
`endif
        m_ovf = drop ? 1'b1 : (clr ? 1'b0 : m_ovf);
        @(negedge clk);
        check_outputs($sformatf("c%0d", cyc));
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, 8'h00, 0, 8'h00, 0, 0);
    endtask

    task automatic rd_pulse();
        repeat (3) cycle(0, 8'h00, 0, 8'h00, 0, 1);
        repeat (3) cycle(0, 8'h00, 0, 8'h00, 0, 0);
    endtask

    task automatic do_reset();
        evFlagA = 0; evFlagB = 0; clrOvf = 0; rdStrb = 0; rd_prev = 0;
        rst_n = 0;
        #1;
        mq.delete(); pop_due.delete(); m_ovf = 0; m_pend = 0;
        check_outputs("rst");
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    int hi_left, lo_left;
    bit rd_r, fa_r, fb_r;

    initial begin
        cyc = 0;
        do_reset();

        // Single push then a host read.
        cycle(1, 8'h60, 0, 8'h00, 0, 0);
        chk("push60 dataOut", 32'(dataOut), 32'h60);
        rd_pulse();
        chk("pop60 count", 32'(count), 32'd0);

        // Simultaneous A+B keep A ahead of B.
        cycle(1, 8'h60, 1, 8'hA1, 0, 0);
        chk("ab count", 32'(count), 32'd2);
        rd_pulse();
        chk("ab head after pop", 32'(dataOut), 32'hA1);
        rd_pulse();

        // Fill to 7, then A+B: A fits, B drops.
        for (int i = 0; i < 7; i++) cycle(1, 8'(8'h20 + i), 0, 8'h00, 0, 0);
        cycle(1, 8'h66, 1, 8'hA6, 0, 0);
        chk("fill count", 32'(count), 32'd8);
        chk("fill ovf", 32'(ovfFlag), 32'd1);
        cycle(1, 8'h55, 0, 8'h00, 1, 0);       // drop and clear together
        chk("clr+drop ovf", 32'(ovfFlag), 32'd1);
        cycle(0, 8'h00, 0, 8'h00, 1, 0);
        chk("clr ovf", 32'(ovfFlag), 32'd0);

        // Pop coincides with push on a full queue.
        cycle(0, 8'h00, 0, 8'h00, 0, 1);
        cycle(0, 8'h00, 0, 8'h00, 0, 1);
        cycle(1, 8'h62, 0, 8'h00, 0, 1);
        chk("full pop+push count", 32'(count), 32'd8);
        chk("full pop+push ovf", 32'(ovfFlag), 32'd0);
        idle(3);
        repeat (10) rd_pulse();                  // drain, then pop on empty

        // Alternating push/pop across pointer wrap.
        for (int i = 0; i < 20; i++) begin
            cycle(1, 8'(8'h80 + i), 0, 8'h00, 0, 0);
            rd_pulse();
        end

        // Reset in the middle of traffic.
        cycle(1, 8'h11, 1, 8'h12, 0, 0);
        cycle(1, 8'h13, 0, 8'h00, 0, 1);
        do_reset();
        idle(2);

        // Randomized traffic: light load first, then heavy load to overflow.
        hi_left = 0; lo_left = 0;
        for (int i = 0; i < 500; i++) begin
            if (hi_left > 0) begin rd_r = 1; hi_left--; end
            else if (lo_left > 0) begin rd_r = 0; lo_left--; end
            else begin
                rd_r = 1;
                hi_left = $urandom_range(2, 4);
                lo_left = $urandom_range(3, 6);
            end
            if (i < 200) begin
                fa_r = ($urandom_range(0, 7) == 0);
                fb_r = ($urandom_range(0, 7) == 0);
            end else begin
                fa_r = ($urandom_range(0, 1) == 0);
                fb_r = ($urandom_range(0, 2) == 0);
            end
            cycle(fa_r, 8'($urandom), fb_r, 8'($urandom),
                  ($urandom_range(0, 15) == 0), rd_r);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
